// File: rtl/credit_pkg.sv
// credit_pkg: shared widths, helper function and credit-return record for the credit FIFO.
package credit_pkg;
  function automatic int clog2_p1(input int n);
    return $clog2(n + 1);
  endfunction
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_CREDIT_BATCH = 1;
  localparam int PTR_W = $clog2(DEF_DEPTH);
  localparam int CNT_W = clog2_p1(DEF_DEPTH);
  localparam int CRED_W = 8;
  typedef struct packed {
    logic valid;
    logic [CRED_W-1:0] amount;
  } credit_ret_t;
endpackage

// File: rtl/credit_fifo_mem.sv
// credit_fifo_mem: DEPTH x DATA_WIDTH register array, one write port, one async read port.
module credit_fifo_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clock)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/credit_fifo_ctrl.sv
// credit_fifo_ctrl: credit-backed FWFT receive FIFO with batched, drain-flushed credit return.
module credit_fifo_ctrl
  import credit_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CREDIT_BATCH = 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              i_valid,
  input  logic [DATA_WIDTH-1:0]             i_data,
  output logic                              o_valid,
  output logic [DATA_WIDTH-1:0]             o_data,
  input  logic                              i_ready,
  output logic                              o_increment_count,
  output logic [clog2_p1(CREDIT_BATCH)-1:0] o_credit_amount,
  output logic [clog2_p1(DEPTH)-1:0]        o_count,
  output logic                              o_overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int NW = clog2_p1(DEPTH);
  localparam int CW = clog2_p1(CREDIT_BATCH);
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [NW-1:0] count, count_next;
  logic [CW-1:0] pend;
  logic full, pop, wr, flush, overflow;
  credit_ret_t ret;
  credit_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
    .clock(clock),
    .we(wr),
    .waddr(wr_ptr),
    .wdata(i_data),
    .raddr(rd_ptr),
    .rdata(o_data)
  );
  assign o_valid = count != '0;
  always_comb begin
    full = count == NW'(DEPTH);
    pop = o_valid && i_ready;
    // a full FIFO still accepts when the head leaves in the same cycle
    wr = i_valid && (!full || pop);
    count_next = count + NW'(wr) - NW'(pop);
    flush = pop && ((pend + 1'b1) == CW'(CREDIT_BATCH) || count_next == '0);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      pend <= '0;
      overflow <= 1'b0;
      ret <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      if (i_valid && full && !pop) overflow <= 1'b1;
      ret.valid <= flush;
      ret.amount <= flush ? CRED_W'(pend) + 1'b1 : '0;
      pend <= flush ? '0 : pop ? pend + 1'b1 : pend;
    end
  end
  assign o_increment_count = ret.valid;
  assign o_credit_amount = CW'(ret.amount);
  assign o_count = count;
  assign o_overflow = overflow;
endmodule
